// File: rtl/multi_sensor_ranger.sv
// Multi-channel ultrasonic ranger: scans N_CH sensors one at a time.
// Each channel gets a trigger pulse, then the echo pulse width is measured
// and converted to centimetres with round-to-nearest and saturation.
// CLK_PER_CM must be at least 2.
module multi_sensor_ranger #(
    parameter int N_CH        = 2,
    parameter int CLK_PER_CM  = 2941,
    parameter int TRIG_CYCLES = 500,
    parameter int ECHO_WAIT   = 50000,
    parameter int MAX_CM      = 60,
    parameter int GAP_CYCLES  = 3000,
    parameter int NEAR_CM     = 10,
    parameter int DIST_W      = 7
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     continuous,
    input  logic [N_CH-1:0]          echo,
    output logic [N_CH-1:0]          trigger,
    output logic [N_CH*DIST_W-1:0]   distance,
    output logic [N_CH-1:0]          valid,
    output logic [N_CH-1:0]          timeout,
    output logic [N_CH-1:0]          near,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               db_state
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = 32;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        TRIG      = 4'd1,
        WAIT_ECHO = 4'd2,
        MEASURE   = 4'd3,
        STORE     = 4'd4,
        GAP       = 4'd5,
        DONE      = 4'd6
    } state_t;

    state_t             state_reg, state_next;
    logic [CH_W-1:0]    ch_reg, ch_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CNT_W-1:0]   sub_reg, sub_next;
    logic [DIST_W-1:0]  cm_reg, cm_next;
    logic [DIST_W-1:0]  result_reg, result_next;
    logic               fail_reg, fail_next;
    logic               keep_reg, keep_next;   // timeout without echo: leave distance alone
    logic               clear_valid;
    logic [N_CH-1:0]    echo_meta_reg, echo_sync_reg;
    logic               echo_cur;

    // Two-flop synchronizer on every echo input
    always_ff @(posedge clock) begin
        if (reset) begin
            echo_meta_reg <= '0;
            echo_sync_reg <= '0;
        end else begin
            echo_meta_reg <= echo;
            echo_sync_reg <= echo_meta_reg;
        end
    end

    // Only the channel currently being scanned is observed
    assign echo_cur = echo_sync_reg[ch_reg];

    // FSM and datapath state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            ch_reg     <= '0;
            cnt_reg    <= '0;
            sub_reg    <= '0;
            cm_reg     <= '0;
            result_reg <= '0;
            fail_reg   <= 1'b0;
            keep_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ch_reg     <= ch_next;
            cnt_reg    <= cnt_next;
            sub_reg    <= sub_next;
            cm_reg     <= cm_next;
            result_reg <= result_next;
            fail_reg   <= fail_next;
            keep_reg   <= keep_next;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next  = state_reg;
        ch_next     = ch_reg;
        cnt_next    = cnt_reg;
        sub_next    = sub_reg;
        cm_next     = cm_reg;
        result_next = result_reg;
        fail_next   = fail_reg;
        keep_next   = keep_reg;
        clear_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = TRIG;
                    ch_next     = '0;
                    cnt_next    = '0;
                    clear_valid = 1'b1;
                end
            end
            TRIG: begin
                if (cnt_reg == CNT_W'(TRIG_CYCLES - 1)) begin
                    state_next = WAIT_ECHO;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WAIT_ECHO: begin
                if (echo_cur) begin
                    // The cycle that reveals the rise is itself the first high cycle
                    state_next = MEASURE;
                    sub_next   = CNT_W'(1);
                    cm_next    = '0;
                end else if (cnt_reg == CNT_W'(ECHO_WAIT - 1)) begin
                    state_next = STORE;
                    fail_next  = 1'b1;
                    keep_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            MEASURE: begin
                if (echo_cur) begin
                    if (cm_reg == DIST_W'(MAX_CM)) begin
                        state_next  = STORE;
                        result_next = DIST_W'(MAX_CM);
                        fail_next   = 1'b1;
                        keep_next   = 1'b0;
                    end else if (sub_reg == CNT_W'(CLK_PER_CM - 1)) begin
                        sub_next = '0;
                        cm_next  = cm_reg + 1'b1;
                    end else begin
                        sub_next = sub_reg + 1'b1;
                    end
                end else begin
                    // Round to nearest centimetre on echo fall
                    state_next  = STORE;
                    result_next = (sub_reg >= CNT_W'(CLK_PER_CM / 2)) ? cm_reg + 1'b1 : cm_reg;
                    fail_next   = 1'b0;
                    keep_next   = 1'b0;
                end
            end
            STORE: begin
                cnt_next = '0;
                if (ch_reg == CH_W'(N_CH - 1)) begin
                    state_next = DONE;
                end else begin
                    state_next = GAP;
                    ch_next    = ch_reg + 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
                    state_next  = TRIG;
                    cnt_next    = '0;
                    clear_valid = (ch_reg == '0);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                ch_next    = '0;
                cnt_next   = '0;
                state_next = continuous ? GAP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-channel result registers and decoded outputs
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [DIST_W-1:0] dist_reg;
        logic              valid_reg;
        logic              timeout_reg;

        // Capture the measurement of this channel in STORE
        always_ff @(posedge clock) begin
            if (reset) begin
                dist_reg    <= '0;
                valid_reg   <= 1'b0;
                timeout_reg <= 1'b0;
            end else if (clear_valid) begin
                valid_reg <= 1'b0;
            end else if (state_reg == STORE && ch_reg == CH_W'(gi)) begin
                if (!keep_reg) begin
                    dist_reg <= result_reg;
                end
                valid_reg   <= 1'b1;
                timeout_reg <= fail_reg;
            end
        end

        assign trigger[gi]                   = (state_reg == TRIG) && (ch_reg == CH_W'(gi));
        assign distance[gi*DIST_W +: DIST_W] = dist_reg;
        assign valid[gi]                     = valid_reg;
        assign timeout[gi]                   = timeout_reg;
        assign near[gi]                      = valid_reg && (dist_reg <= DIST_W'(NEAR_CM));
    end

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign db_state = state_reg;

endmodule

// File: tb/tb_multi_sensor_ranger.sv
// Directed bench for multi_sensor_ranger. Timing parameters are scaled down
// (21 clocks per cm, half = 10) so that every scenario fits a short run;
// expected distances are hand-computed from those values.
module tb_multi_sensor_ranger;

    localparam int N_CH  = 2;
    localparam int CPC   = 21;
    localparam int TRIGC = 10;
    localparam int EW    = 200;
    localparam int MAXC  = 60;
    localparam int GAPC  = 30;
    localparam int NEARC = 10;
    localparam int DW    = 7;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              continuous;
    logic [N_CH-1:0]   echo;
    logic [N_CH-1:0]   trigger;
    logic [N_CH*DW-1:0] distance;
    logic [N_CH-1:0]   valid;
    logic [N_CH-1:0]   timeout;
    logic [N_CH-1:0]   near;
    logic              busy;
    logic              done;
    logic [3:0]        db_state;
    logic [DW-1:0]     d0, d1;

    int n_checks = 0;
    int n_pass   = 0;

    multi_sensor_ranger #(
        .N_CH(N_CH), .CLK_PER_CM(CPC), .TRIG_CYCLES(TRIGC), .ECHO_WAIT(EW),
        .MAX_CM(MAXC), .GAP_CYCLES(GAPC), .NEAR_CM(NEARC), .DIST_W(DW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .continuous(continuous),
        .echo(echo), .trigger(trigger), .distance(distance), .valid(valid),
        .timeout(timeout), .near(near), .busy(busy), .done(done),
        .db_state(db_state)
    );

    assign d0 = distance[0 +: DW];
    assign d1 = distance[DW +: DW];

    always #5 clock = ~clock;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait for trigger[ch], then return its width; ends on the first WAIT_ECHO sample
    task automatic wait_trig(input int ch, output int width);
        int g = 0;
        while (!trigger[ch] && g < 2000) begin
            tick();
            g++;
        end
        check($sformatf("trig%0d_seen", ch), int'(trigger[ch]), 1);
        width = 0;
        while (trigger[ch] && width < 5000) begin
            width++;
            tick();
        end
    endtask

    task automatic echo_pulse(input int ch, input int cycles);
        echo[ch] = 1'b1;
        repeat (cycles) tick();
        echo[ch] = 1'b0;
    endtask

    // Wait for done, then confirm it lasts exactly one cycle
    task automatic wait_done(input int budget, input string tag);
        int g = 0;
        while (!done && g < budget) begin
            tick();
            g++;
        end
        check({tag, "_done"}, int'(done), 1);
    endtask

    task automatic done_single(input string tag);
        tick();
        check({tag, "_done_1cyc"}, int'(done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int g;
        reset = 1'b1; start = 1'b0; continuous = 1'b0; echo = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_state", db_state, 0);
        check("rst_trig", trigger, 0);
        check("rst_valid", valid, 0);
        check("rst_dist", distance, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // Scan 1: ch0 147 cycles -> 7 cm, ch1 157 cycles -> 8 cm
        pulse_start();
        check("s1_state", db_state, 1);
        check("s1_busy", busy, 1);
        wait_trig(0, w);
        check("s1_trig0_w", w, TRIGC);
        echo_pulse(0, 147);
        wait_trig(1, w);
        check("s1_trig1_w", w, TRIGC);
        echo_pulse(1, 157);
        wait_done(100, "s1");
        $display("scan1: d0=%0d d1=%0d valid=%b near=%b timeout=%b", d0, d1, valid, near, timeout);
        check("s1_d0", d0, 7);
        check("s1_d1", d1, 8);
        check("s1_valid", valid, 2'b11);
        check("s1_near", near, 2'b11);
        check("s1_timeout", timeout, 2'b00);
        done_single("s1");
        check("s1_idle", db_state, 0);
        check("s1_busy_fall", busy, 0);

        // Scan 2: ch0 157 cycles -> 8 cm, ch1 silent -> timeout, distance kept
        pulse_start();
        check("s2_valid_clr", valid, 2'b00);
        check("s2_near_clr", near, 2'b00);
        wait_trig(0, w);
        echo_pulse(0, 157);
        wait_trig(1, w);
        g = 0;
        while (db_state == 2 && g < EW + 20) begin
            tick();
            g++;
        end
        check("s2_wait_len", g, EW);
        wait_done(50, "s2");
        $display("scan2: d0=%0d d1=%0d valid=%b timeout=%b", d0, d1, valid, timeout);
        check("s2_d0", d0, 8);
        check("s2_t0", timeout[0], 0);
        check("s2_t1", timeout[1], 1);
        check("s2_v1", valid[1], 1);
        check("s2_d1_kept", d1, 8);
        done_single("s2");
        check("s2_busy_fall", busy, 0);

        // Scan 3: echo0 high before start and held -> saturation, then gap, ch1 156 -> 7
        echo[0] = 1'b1;
        repeat (3) tick();
        pulse_start();
        wait_trig(0, w);
        check("s3_trig0_w", w, TRIGC);
        g = 0;
        while (db_state != 5 && g < 3000) begin
            tick();
            g++;
        end
        check("s3_gap_seen", db_state, 5);
        check("s3_d0_sat", d0, MAXC);
        check("s3_t0", timeout[0], 1);
        check("s3_v0", valid[0], 1);
        check("s3_near0", near[0], 0);
        g = 0;
        while (db_state == 5 && g < 1000) begin
            tick();
            g++;
        end
        check("s3_gap_len", g, GAPC);
        check("s3_trig_after_gap", trigger, 2'b10);
        wait_trig(1, w);
        check("s3_trig1_w", w, TRIGC);
        echo_pulse(1, 156);
        wait_done(100, "s3");
        $display("scan3: d0=%0d d1=%0d timeout=%b near=%b", d0, d1, timeout, near);
        check("s3_d1", d1, 7);
        check("s3_t1", timeout[1], 0);
        check("s3_near1", near[1], 1);
        done_single("s3");
        echo[0] = 1'b0;
        repeat (5) tick();

        // Continuous: two scans, clear continuous during the second
        continuous = 1'b1;
        pulse_start();
        for (int s = 0; s < 2; s++) begin
            wait_trig(0, w);
            echo_pulse(0, 21);
            if (s == 1) continuous = 1'b0;
            wait_trig(1, w);
            echo_pulse(1, 420);
            wait_done(100, $sformatf("c%0d", s));
            $display("cont scan %0d: d0=%0d d1=%0d near=%b timeout=%b", s, d0, d1, near, timeout);
            check($sformatf("c%0d_d0", s), d0, 1);
            check($sformatf("c%0d_d1", s), d1, 20);
            check($sformatf("c%0d_near", s), near, 2'b01);
            check($sformatf("c%0d_timeout", s), timeout, 2'b00);
            done_single($sformatf("c%0d", s));
            check($sformatf("c%0d_next_state", s), db_state, (s == 0) ? 5 : 0);
        end
        check("c_busy_fall", busy, 0);

        // Reset during MEASURE of ch1, then a fresh scan
        pulse_start();
        wait_trig(0, w);
        echo_pulse(0, 147);
        wait_trig(1, w);
        echo[1] = 1'b1;
        repeat (6) tick();
        check("r_in_measure", db_state, 3);
        reset = 1'b1;
        tick();
        echo[1] = 1'b0;
        $display("mid-scan reset: state=%0d busy=%b valid=%b dist=%0d", db_state, busy, valid, distance);
        check("r_state", db_state, 0);
        check("r_busy", busy, 0);
        check("r_trig", trigger, 0);
        check("r_dist", distance, 0);
        check("r_valid", valid, 0);
        check("r_timeout", timeout, 0);
        check("r_near", near, 0);
        check("r_done", done, 0);
        reset = 1'b0;
        pulse_start();
        check("r_restart_state", db_state, 1);
        check("r_restart_trig", trigger, 2'b01);
        wait_trig(0, w);
        echo_pulse(0, 147);
        wait_trig(1, w);
        echo_pulse(1, 21);
        wait_done(100, "r");
        $display("post-reset scan: d0=%0d d1=%0d valid=%b", d0, d1, valid);
        check("r_d0", d0, 7);
        check("r_d1", d1, 1);
        check("r_valid_after", valid, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_sensor_ranger.md
MULTI_SENSOR_RANGER -- requirements
Module: multi_sensor_ranger

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of ultrasonic channels (1..8).
REQ-002 SHALL have parameter CLK_PER_CM, default 2941, clock cycles of echo per centimetre.
REQ-003 SHALL have parameter TRIG_CYCLES, default 500, trigger pulse width in cycles (10 us at 50 MHz).
REQ-004 SHALL have parameter ECHO_WAIT, default 50000, maximum cycles from trigger fall to echo rise.
REQ-005 SHALL have parameter MAX_CM, default 60, distance saturation limit in cm.
REQ-006 SHALL have parameter GAP_CYCLES, default 3000, settle cycles between channels.
REQ-007 SHALL have parameter NEAR_CM, default 10, proximity threshold in cm.
REQ-008 SHALL have parameter DIST_W, default 7, distance field width (2^DIST_W > MAX_CM).
REQ-009 Ports, clock and reset first:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request for one scan of all channels.
- continuous  in  1  1 = rescan automatically after each scan.
- echo  in  N_CH  asynchronous echo inputs, one per sensor.
- trigger  out  N_CH  trigger pulses, at most one bit high at a time.
- distance  out  N_CH*DIST_W  last result per channel; channel k at bits [k*DIST_W +: DIST_W].
- valid  out  N_CH  channel has a result from the most recent scan.
- timeout  out  N_CH  channel's most recent measurement failed.
- near  out  N_CH  valid and distance <= NEAR_CM.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at end of each scan.
- db_state  out  4  FSM state code, for debug.

Function
REQ-010 Each echo bit SHALL pass through a 2-flop synchronizer; all timing is measured on the synchronized signal.
REQ-011 FSM states and codes: IDLE=0, TRIG=1, WAIT_ECHO=2, MEASURE=3, STORE=4, GAP=5, DONE=6; db_state SHALL show the current code.
REQ-012 IDLE: start=1 -> TRIG with channel index ch=0, cycle counter cleared; start is ignored in every other state.
REQ-013 TRIG: trigger[ch]=1 for exactly TRIG_CYCLES cycles, then WAIT_ECHO.
REQ-014 WAIT_ECHO: synchronized echo[ch] high -> MEASURE; after ECHO_WAIT cycles with no rise -> STORE with timeout[ch]=1 and distance unchanged.
REQ-015 MEASURE: a sub-counter counts the cycles echo is high; at CLK_PER_CM-1 it wraps to 0 and the cm counter increments.
REQ-016 On echo fall: result = cm + 1 if sub-counter >= CLK_PER_CM/2 (integer division), else cm -> STORE.
REQ-017 If the cm counter reaches MAX_CM while echo is still high, the result SHALL saturate at MAX_CM, timeout[ch]=1, and the FSM goes to STORE without waiting for echo fall.
REQ-018 STORE (1 cycle): write distance[ch], set valid[ch]=1, set timeout[ch] as determined, update near[ch].
REQ-019 After STORE, ch < N_CH-1 -> GAP for GAP_CYCLES, then TRIG with ch+1.
REQ-020 After STORE, ch = N_CH-1 -> DONE.
REQ-021 DONE (1 cycle): done=1, then IDLE; if continuous=1, go to TRIG with ch=0 after GAP_CYCLES in GAP instead.
REQ-022 On entry to TRIG for ch=0, all valid bits SHALL clear; near follows valid.
REQ-023 busy=1 in every state except IDLE.
REQ-024 An echo already high on entry to WAIT_ECHO SHALL be treated as a rise (measurement starts immediately).
REQ-025 Echo pulses on channels other than ch SHALL be ignored.
REQ-026 Clearing continuous mid-scan SHALL let the current scan complete, then return to IDLE.

Reset
REQ-027 On reset=1 at a clock edge, the following SHALL apply, even mid-scan:
- FSM to IDLE, ch=0, all counters 0.
- trigger=0, distance=0, valid=0, timeout=0, near=0.
- busy=0, done=0, db_state=0, synchronizers cleared.
REQ-028 The first start after reset release SHALL be accepted the cycle it is seen.

Verification
REQ-029 Defaults, start pulse -> trigger[0] high exactly 500 cycles; echo[0] high 20587 cycles -> distance ch0=7, valid[0]=1, near[0]=1, timeout[0]=0.
REQ-030 Echo[0] high 22057 cycles -> distance ch0=8; echo[0] high 22056 cycles -> distance ch0=7 (rounding boundary).
REQ-031 Echo[1] never rises -> after 50000 wait cycles timeout[1]=1, valid[1]=1, distance ch1 retains prior value, done pulses once, busy falls.
REQ-032 Echo[0] held high indefinitely -> distance ch0=60, timeout[0]=1, FSM advances to ch1 with gap 3000 cycles, trigger[1] follows.
REQ-033 continuous=1 with fixed echoes 2941 cycles (ch0) and 58820 cycles (ch1) -> repeated scans, each ending in one done pulse; ch0=1 with near=1, ch1=20 with near=0.
REQ-034 reset asserted during MEASURE of ch1 -> next cycle all outputs 0, db_state=0; a new start yields a fresh scan from ch0.
